// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder: start handshake, operands in, sum and flags out.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Ready;
  logic             Done;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             Ovf;

  modport master (output Start, A, B, Cin, input Ready, Done, S, Cout, Ovf);
  modport slave  (input Start, A, B, Cin, output Ready, Done, S, Cout, Ovf);
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH-bit A+B+Cin through one DIGIT-bit slice, WIDTH/DIGIT cycles per op.
// Result, carry and signed-overflow are registered at completion and held until the next one.
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input logic           CLK,
  input logic           RST,
  serial_adder_if.slave bus
);
  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW    = DIGIT + 1;

  if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, a_nxt, b_q, b_nxt;
  logic [WIDTH-1:0] acc_q, acc_nxt, s_q, s_nxt;
  logic             carry_q, carry_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             ready_q, ready_nxt, done_q, done_nxt;
  logic             cout_q, cout_nxt, ovf_q, ovf_nxt;

  logic [DIGIT-1:0] a_dig, b_dig;
  logic [SW-1:0]    slice;
  logic             msb_cin;

  // Shared digit slice; msb_cin recovers the carry into the top bit for the overflow flag.
  assign a_dig   = a_q[DIGIT-1:0];
  assign b_dig   = b_q[DIGIT-1:0];
  assign slice   = SW'(a_dig) + SW'(b_dig) + SW'(carry_q);
  assign msb_cin = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ slice[DIGIT-1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      a_q     <= a_nxt;
      b_q     <= b_nxt;
      acc_q   <= acc_nxt;
      s_q     <= s_nxt;
      carry_q <= carry_nxt;
      cnt_q   <= cnt_nxt;
      ready_q <= ready_nxt;
      done_q  <= done_nxt;
      cout_q  <= cout_nxt;
      ovf_q   <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    a_nxt     = a_q;
    b_nxt     = b_q;
    acc_nxt   = acc_q;
    s_nxt     = s_q;
    carry_nxt = carry_q;
    cnt_nxt   = cnt_q;
    cout_nxt  = cout_q;
    ovf_nxt   = ovf_q;
    done_nxt  = 1'b0;

    unique case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (bus.Start) begin
          state_nxt = RUN;
          a_nxt     = bus.A;
          b_nxt     = bus.B;
          carry_nxt = bus.Cin;
          acc_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        // Partial sum builds in acc_q so S only ever shows completed results.
        acc_nxt   = (acc_q >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
        a_nxt     = a_q >> DIGIT;
        b_nxt     = b_q >> DIGIT;
        carry_nxt = slice[DIGIT];
        cnt_nxt   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          state_nxt = DONE;
          s_nxt     = acc_nxt;
          cout_nxt  = slice[DIGIT];
          ovf_nxt   = msb_cin ^ slice[DIGIT];
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    ready_nxt = (state_nxt != RUN);
  end

  assign bus.Ready = ready_q;
  assign bus.Done  = done_q;
  assign bus.S     = s_q;
  assign bus.Cout  = cout_q;
  assign bus.Ovf   = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: one DIGIT=1 and one DIGIT=4 instance, both WIDTH=8.
module tb_serial_adder;
  localparam int unsigned WIDTH = 8;

  typedef struct packed {
    logic [7:0] s;
    logic       cout;
    logic       ovf;
  } res_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  serial_adder_if #(.WIDTH(WIDTH)) bus1 ();
  serial_adder_if #(.WIDTH(WIDTH)) bus4 ();

  serial_adder #(.WIDTH(WIDTH), .DIGIT(1)) u_dut1 (.CLK(CLK), .RST(RST), .bus(bus1));
  serial_adder #(.WIDTH(WIDTH), .DIGIT(4)) u_dut4 (.CLK(CLK), .RST(RST), .bus(bus4));

  res_t q1[$];
  res_t q4[$];
  res_t mon1, mon4;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic cin);
    logic [8:0] full;
    res_t       r;
    full   = {1'b0, a} + {1'b0, b} + 9'(cin);
    r.s    = full[7:0];
    r.cout = full[8];
    r.ovf  = (a[7] == b[7]) && (r.s[7] != a[7]);
    return r;
  endfunction

  // Completion monitor: every Done pulse pops and compares one expected result.
  always @(negedge CLK) begin
    if (!RST && bus1.Done) begin
      if (q1.size() == 0) check("dut1_spurious_done", 1, 0);
      else begin
        mon1 = q1.pop_front();
        check("dut1_S", 32'(bus1.S), 32'(mon1.s));
        check("dut1_Cout", 32'(bus1.Cout), 32'(mon1.cout));
        check("dut1_Ovf", 32'(bus1.Ovf), 32'(mon1.ovf));
      end
    end
    if (!RST && bus4.Done) begin
      if (q4.size() == 0) check("dut4_spurious_done", 1, 0);
      else begin
        mon4 = q4.pop_front();
        check("dut4_S", 32'(bus4.S), 32'(mon4.s));
        check("dut4_Cout", 32'(bus4.Cout), 32'(mon4.cout));
        check("dut4_Ovf", 32'(bus4.Ovf), 32'(mon4.ovf));
      end
    end
  end

  task automatic drive(input bit sel, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input bit st);
    if (!sel) begin
      bus1.A = a; bus1.B = b; bus1.Cin = cin; bus1.Start = st;
    end else begin
      bus4.A = a; bus4.B = b; bus4.Cin = cin; bus4.Start = st;
    end
  endtask

  task automatic wait_ready(input bit sel);
    int n = 0;
    while (!(sel ? bus4.Ready : bus1.Ready) && n < 60) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 60) check("ready_timeout", 0, 1);
  endtask

  task automatic wait_done(input bit sel);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(sel ? bus4.Done : bus1.Done) && n < 60);
    if (!(sel ? bus4.Done : bus1.Done)) check("done_timeout", 0, 1);
  endtask

  // One op with latency and Ready-low measurement; result checked by the monitor.
  task automatic timed_op(input bit sel, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input int exp_n);
    int lat  = 999;
    int rlow = 0;
    bit seen = 0;
    wait_ready(sel);
    drive(sel, a, b, cin, 1'b1);
    if (!sel) q1.push_back(model(a, b, cin)); else q4.push_back(model(a, b, cin));
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(negedge CLK);
      if (k == 1) drive(sel, a, b, cin, 1'b0);
      if (!(sel ? bus4.Ready : bus1.Ready)) rlow++;
      if (sel ? bus4.Done : bus1.Done) begin
        seen = 1;
        lat  = k - 1;
      end
    end
    check(sel ? "dut4_latency" : "dut1_latency", 32'(lat), 32'(exp_n));
    check(sel ? "dut4_ready_low" : "dut1_ready_low", 32'(rlow), 32'(exp_n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit saw_done;
    drive(0, 8'h00, 8'h00, 1'b0, 1'b0);
    drive(1, 8'h00, 8'h00, 1'b0, 1'b0);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_ready", 32'(bus1.Ready), 1);
    check("rst_done", 32'(bus1.Done), 0);
    check("rst_S", 32'(bus1.S), 0);
    check("rst_flags", 32'({bus1.Cout, bus1.Ovf}), 0);
    check("rst4_ready", 32'(bus4.Ready), 1);
    check("rst4_S", 32'(bus4.S), 0);
    RST = 1'b0;
    @(negedge CLK);

    timed_op(0, 8'hFF, 8'h01, 1'b0, 8);
    timed_op(0, 8'h7F, 8'h01, 1'b0, 8);
    timed_op(0, 8'hFF, 8'hFF, 1'b1, 8);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check("hold_S", 32'(bus1.S), 32'h0FF);
      check("hold_flags", 32'({bus1.Cout, bus1.Ovf}), 32'b10);
    end
    timed_op(1, 8'h5A, 8'hA5, 1'b1, 2);

    // Start held high, operands churning during RUN, relaunch in the Done cycle.
    wait_ready(0);
    drive(0, 8'h12, 8'h34, 1'b0, 1'b1);
    q1.push_back(model(8'h12, 8'h34, 1'b0));
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (bus1.Done) begin
        drive(0, 8'h56, 8'h78, 1'b1, 1'b1);
        q1.push_back(model(8'h56, 8'h78, 1'b1));
        break;
      end
      drive(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    end
    @(negedge CLK);
    drive(0, 8'h00, 8'h00, 1'b0, 1'b0);
    check("b2b_no_idle", 32'(bus1.Ready), 0);
    wait_done(0);

    // Reset three cycles into an op: aborted with no Done.
    wait_ready(0);
    drive(0, 8'hAA, 8'h55, 1'b0, 1'b1);
    @(negedge CLK);
    drive(0, 8'hAA, 8'h55, 1'b0, 1'b0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("abort_ready", 32'(bus1.Ready), 1);
    check("abort_S", 32'(bus1.S), 0);
    check("abort_flags", 32'({bus1.Cout, bus1.Ovf, bus1.Done}), 0);
    saw_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (bus1.Done) saw_done = 1;
    end
    check("abort_no_done", 32'(saw_done), 0);
    timed_op(0, 8'h03, 8'h04, 1'b0, 8);

    for (int i = 0; i < 8; i++) begin
      timed_op(0, 8'($urandom), 8'($urandom), 1'($urandom), 8);
      timed_op(1, 8'($urandom), 8'($urandom), 1'($urandom), 2);
    end

    repeat (3) @(negedge CLK);
    check("q1_drained", 32'(q1.size()), 0);
    check("q4_drained", 32'(q4.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
